// File: rtl/writeback_stage_if.sv
// writeback_stage_if: stage-3 operands, data-memory read handshake and commit outputs of the writeback stage
`ifndef LOAD
`define LOAD 5'h10
`endif
`ifndef STORE
`define STORE 5'h11
`endif
interface writeback_stage_if;
  logic [7:0]  ALUStatusOut3;
  logic [31:0] ALUOut3;
  logic [31:0] ALUOverflow3;
  logic [4:0]  Opc3;
  logic [3:0]  Rc3;
  logic        Cmp3;
  logic [2:0]  Cond3;
  logic        memReady;
  logic [31:0] dataIn;
  logic        regWriteEn;
  logic [3:0]  regWriteAddr;
  logic [31:0] regWriteData;
  logic [7:0]  statusReg;
  logic [31:0] overflowReg;
  logic        stall;
  logic        memErr;
  modport master(
    output ALUStatusOut3, ALUOut3, ALUOverflow3, Opc3, Rc3, Cmp3, Cond3, memReady, dataIn,
    input  regWriteEn, regWriteAddr, regWriteData, statusReg, overflowReg, stall, memErr
  );
  modport slave(
    input  ALUStatusOut3, ALUOut3, ALUOverflow3, Opc3, Rc3, Cmp3, Cond3, memReady, dataIn,
    output regWriteEn, regWriteAddr, regWriteData, statusReg, overflowReg, stall, memErr
  );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: condition evaluation and result commit, with LOAD stall on the data-memory read handshake
module writeback_stage #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  writeback_stage_if.slave bus
);
  typedef enum logic {RUN, WAIT_MEM} state_t;
  state_t r_state, w_next;
  logic [7:0]  r_cnt;
  logic [3:0]  r_rc;
  logic [7:0]  w_conds;
  logic        w_pass, w_load, w_op, w_waiting, w_tmo, w_mem_done, w_err, w_we, w_st_en, w_ov_en;
  logic [31:0] w_wdata;
  logic [3:0]  w_waddr;
  // condition table indexed by Cond3: always, Z, !Z, N, !N, C, !C, never
  assign w_conds = {1'b0, ~bus.statusReg[2], bus.statusReg[2], ~bus.statusReg[1],
                    bus.statusReg[1], ~bus.statusReg[0], bus.statusReg[0], 1'b1};
  // decode the current cycle: what commits and where the FSM goes next
  always_comb begin
    w_pass     = w_conds[bus.Cond3];
    w_load     = r_state == RUN && w_pass && bus.Opc3 == `LOAD;
    w_op       = r_state == RUN && w_pass && bus.Opc3 != `LOAD && bus.Opc3 != `STORE;
    w_waiting  = r_state == WAIT_MEM;
    w_tmo      = w_waiting && r_cnt == 8'(MEM_TIMEOUT - 1);
    w_mem_done = (w_load || w_waiting) && bus.memReady;
    w_err      = w_tmo && !bus.memReady;
    w_next     = ((w_load || w_waiting) && !bus.memReady && !w_tmo) ? WAIT_MEM : RUN;
    w_st_en    = w_op && bus.Cmp3;
    w_ov_en    = w_op && !bus.Cmp3;
    w_we       = w_mem_done || w_err || w_ov_en;
    w_wdata    = w_mem_done ? bus.dataIn : w_err ? 32'd0 : bus.ALUOut3;
    w_waddr    = w_waiting ? r_rc : bus.Rc3;
  end
  // stall follows the next state so a LOAD stalls in the very cycle it is presented
  assign bus.stall = rst && w_next == WAIT_MEM;
  // architectural state, commit registers and the memory-wait counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= RUN;
      r_cnt            <= 8'd0;
      r_rc             <= 4'd0;
      bus.regWriteEn   <= 1'b0;
      bus.regWriteAddr <= 4'd0;
      bus.regWriteData <= 32'd0;
      bus.statusReg    <= 8'd0;
      bus.overflowReg  <= 32'd0;
      bus.memErr       <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_cnt          <= (w_waiting && w_next == WAIT_MEM) ? r_cnt + 8'd1 : 8'd0;
      r_rc           <= w_waiting ? r_rc : bus.Rc3;
      bus.regWriteEn <= w_we;
      if (w_we) begin
        bus.regWriteAddr <= w_waddr;
        bus.regWriteData <= w_wdata;
      end
      if (w_st_en) bus.statusReg <= bus.ALUStatusOut3;
      if (w_ov_en) bus.overflowReg <= bus.ALUOverflow3;
      if (w_err) bus.memErr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed self-checking bench for the writeback stage (MEM_TIMEOUT=4)
`ifndef LOAD
`define LOAD 5'h10
`endif
`ifndef STORE
`define STORE 5'h11
`endif
module tb_writeback_stage;
  localparam logic [4:0] ADD = 5'h01;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  writeback_stage_if bus();
  writeback_stage #(.MEM_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [4:0] opc, input logic [3:0] rc, input logic [31:0] res,
                       input logic [31:0] ovf, input logic [7:0] st, input logic cmp, input logic [2:0] cond);
    bus.Opc3 = opc; bus.Rc3 = rc; bus.ALUOut3 = res; bus.ALUOverflow3 = ovf;
    bus.ALUStatusOut3 = st; bus.Cmp3 = cmp; bus.Cond3 = cond;
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b0; bus.memReady = 1'b0; bus.dataIn = 32'hFFFF_FFFF;
    drive(`LOAD, 4'hF, 32'hCAFE_F00D, 32'h55, 8'hFF, 1'b0, 3'd0);
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall_comb got %b want 0", bus.stall); end
    tick(); tick();
    n_cmp++; if (bus.regWriteEn !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b want 0", bus.regWriteEn); end
    n_cmp++; if (bus.regWriteData !== 32'd0 || bus.regWriteAddr !== 4'd0) begin n_fail++; $display("FAIL rst_wr got %h/%h want 0/0", bus.regWriteAddr, bus.regWriteData); end
    n_cmp++; if (bus.statusReg !== 8'd0 || bus.overflowReg !== 32'd0) begin n_fail++; $display("FAIL rst_arch got %h/%h want 0/0", bus.statusReg, bus.overflowReg); end
    n_cmp++; if (bus.memErr !== 1'b0 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst_err_stall got %b/%b want 0/0", bus.memErr, bus.stall); end
    drive(`STORE, 4'h3, 32'h1, 32'h1, 8'h0, 1'b0, 3'd0);
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.regWriteEn !== 1'b0) begin n_fail++; $display("FAIL rst_store_we got %b want 0", bus.regWriteEn); end
  endtask
  task automatic test_alu();
    drive(ADD, 4'd5, 32'h1234_5678, 32'd1, 8'h00, 1'b0, 3'd0);
    tick();
    n_cmp++; if (bus.regWriteEn !== 1'b1 || bus.regWriteAddr !== 4'd5) begin n_fail++; $display("FAIL alu_we_addr got %b/%0d want 1/5", bus.regWriteEn, bus.regWriteAddr); end
    n_cmp++; if (bus.regWriteData !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_data got %h want 12345678", bus.regWriteData); end
    n_cmp++; if (bus.overflowReg !== 32'd1) begin n_fail++; $display("FAIL alu_ovf got %h want 1", bus.overflowReg); end
    drive(`STORE, 4'd9, 32'h9999, 32'h77, 8'h00, 1'b0, 3'd0);
    tick();
    n_cmp++; if (bus.regWriteEn !== 1'b0 || bus.regWriteAddr !== 4'd5 || bus.regWriteData !== 32'h1234_5678) begin n_fail++; $display("FAIL store_hold got %b/%0d/%h want 0/5/12345678", bus.regWriteEn, bus.regWriteAddr, bus.regWriteData); end
    n_cmp++; if (bus.overflowReg !== 32'd1) begin n_fail++; $display("FAIL store_ovf got %h want 1", bus.overflowReg); end
  endtask
  task automatic test_cmp_cond();
    drive(ADD, 4'd2, 32'hAAAA, 32'h3, 8'h01, 1'b1, 3'd0);
    tick();
    n_cmp++; if (bus.statusReg !== 8'h01 || bus.regWriteEn !== 1'b0) begin n_fail++; $display("FAIL cmp_status got %h/%b want 01/0", bus.statusReg, bus.regWriteEn); end
    n_cmp++; if (bus.overflowReg !== 32'd1) begin n_fail++; $display("FAIL cmp_ovf got %h want 1", bus.overflowReg); end
    drive(ADD, 4'd3, 32'hAAAA, 32'h2, 8'h00, 1'b0, 3'd2);
    tick();
    n_cmp++; if (bus.regWriteEn !== 1'b0 || bus.overflowReg !== 32'd1) begin n_fail++; $display("FAIL cond_nz got %b/%h want 0/1", bus.regWriteEn, bus.overflowReg); end
    drive(ADD, 4'd3, 32'hBBBB, 32'h2, 8'h00, 1'b0, 3'd1);
    tick();
    n_cmp++; if (bus.regWriteEn !== 1'b1 || bus.regWriteAddr !== 4'd3 || bus.regWriteData !== 32'hBBBB) begin n_fail++; $display("FAIL cond_z got %b/%0d/%h want 1/3/0000bbbb", bus.regWriteEn, bus.regWriteAddr, bus.regWriteData); end
    drive(ADD, 4'd0, 32'h0, 32'h0, 8'hF6, 1'b1, 3'd7);
    tick();
    n_cmp++; if (bus.statusReg !== 8'h01 || bus.regWriteEn !== 1'b0) begin n_fail++; $display("FAIL cond_never got %h/%b want 01/0", bus.statusReg, bus.regWriteEn); end
    drive(ADD, 4'd0, 32'h0, 32'h0, 8'hF6, 1'b1, 3'd2);
    tick();
    n_cmp++; if (bus.statusReg !== 8'h01) begin n_fail++; $display("FAIL cmp_condfail got %h want 01", bus.statusReg); end
    drive(ADD, 4'd0, 32'h0, 32'h0, 8'hF6, 1'b1, 3'd1);
    tick();
    n_cmp++; if (bus.statusReg !== 8'hF6) begin n_fail++; $display("FAIL cmp_upper got %h want f6", bus.statusReg); end
    drive(ADD, 4'd4, 32'hC0C0, 32'h0, 8'h00, 1'b0, 3'd5);
    tick();
    n_cmp++; if (bus.regWriteEn !== 1'b1 || bus.regWriteData !== 32'hC0C0) begin n_fail++; $display("FAIL cond_c got %b/%h want 1/0000c0c0", bus.regWriteEn, bus.regWriteData); end
    drive(ADD, 4'd4, 32'hD0D0, 32'h0, 8'h00, 1'b0, 3'd6);
    tick();
    n_cmp++; if (bus.regWriteEn !== 1'b0) begin n_fail++; $display("FAIL cond_nc got %b want 0", bus.regWriteEn); end
    drive(ADD, 4'd4, 32'hE0E0, 32'h0, 8'h00, 1'b0, 3'd3);
    tick();
    n_cmp++; if (bus.regWriteEn !== 1'b1 || bus.regWriteData !== 32'hE0E0) begin n_fail++; $display("FAIL cond_n got %b/%h want 1/0000e0e0", bus.regWriteEn, bus.regWriteData); end
    drive(ADD, 4'd4, 32'hF0F0, 32'h0, 8'h00, 1'b0, 3'd4);
    tick();
    n_cmp++; if (bus.regWriteEn !== 1'b0) begin n_fail++; $display("FAIL cond_nn got %b want 0", bus.regWriteEn); end
    drive(`LOAD, 4'd8, 32'h0, 32'h0, 8'h00, 1'b0, 3'd7);
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL load_condfail_stall got %b want 0", bus.stall); end
    tick();
    n_cmp++; if (bus.regWriteEn !== 1'b0) begin n_fail++; $display("FAIL load_condfail_we got %b want 0", bus.regWriteEn); end
  endtask
  task automatic test_load();
    drive(`LOAD, 4'd7, 32'h1111, 32'h0, 8'h00, 1'b0, 3'd0);
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (bus.stall !== 1'b1 || bus.regWriteEn !== 1'b0) begin n_fail++; $display("FAIL load_wait%0d got stall %b we %b want 1/0", c, bus.stall, bus.regWriteEn); end
      tick();
    end
    bus.memReady = 1'b1; bus.dataIn = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL load_ready_stall got %b want 0", bus.stall); end
    tick();
    bus.memReady = 1'b0;
    drive(`STORE, 4'd1, 32'h0, 32'h0, 8'h00, 1'b0, 3'd0);
    n_cmp++; if (bus.regWriteEn !== 1'b1 || bus.regWriteAddr !== 4'd7 || bus.regWriteData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_wr got %b/%0d/%h want 1/7/deadbeef", bus.regWriteEn, bus.regWriteAddr, bus.regWriteData); end
    n_cmp++; if (bus.memErr !== 1'b0 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL load_err got %b/%b want 0/0", bus.memErr, bus.stall); end
    drive(`LOAD, 4'd9, 32'h0, 32'h0, 8'h00, 1'b0, 3'd0);
    bus.memReady = 1'b1; bus.dataIn = 32'h55;
    #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL load_imm_stall got %b want 0", bus.stall); end
    tick();
    bus.memReady = 1'b0;
    n_cmp++; if (bus.regWriteEn !== 1'b1 || bus.regWriteAddr !== 4'd9 || bus.regWriteData !== 32'h55) begin n_fail++; $display("FAIL load_imm_wr got %b/%0d/%h want 1/9/00000055", bus.regWriteEn, bus.regWriteAddr, bus.regWriteData); end
  endtask
  task automatic test_timeout();
    drive(`LOAD, 4'd7, 32'h0, 32'h0, 8'h00, 1'b0, 3'd0);
    for (int c = 0; c < 4; c++) tick();
    bus.memReady = 1'b1; bus.dataIn = 32'h1234;
    #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL tmo_ready_stall got %b want 0", bus.stall); end
    tick();
    bus.memReady = 1'b0;
    n_cmp++; if (bus.regWriteEn !== 1'b1 || bus.regWriteData !== 32'h1234 || bus.memErr !== 1'b0) begin n_fail++; $display("FAIL tmo_ready got %b/%h/%b want 1/00001234/0", bus.regWriteEn, bus.regWriteData, bus.memErr); end
    drive(`LOAD, 4'd7, 32'h0, 32'h0, 8'h00, 1'b0, 3'd0);
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL tmo_stall%0d got %b want 1", c, bus.stall); end
      tick();
    end
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL tmo_exit_stall got %b want 0", bus.stall); end
    tick();
    drive(`STORE, 4'd1, 32'h0, 32'h0, 8'h00, 1'b0, 3'd0);
    n_cmp++; if (bus.regWriteEn !== 1'b1 || bus.regWriteAddr !== 4'd7 || bus.regWriteData !== 32'd0) begin n_fail++; $display("FAIL tmo_wr got %b/%0d/%h want 1/7/0", bus.regWriteEn, bus.regWriteAddr, bus.regWriteData); end
    n_cmp++; if (bus.memErr !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %b want 1", bus.memErr); end
    tick();
    n_cmp++; if (bus.stall !== 1'b0 || bus.regWriteEn !== 1'b0 || bus.memErr !== 1'b1) begin n_fail++; $display("FAIL tmo_after got %b/%b/%b want 0/0/1", bus.stall, bus.regWriteEn, bus.memErr); end
  endtask
  task automatic test_reset_mid();
    drive(`LOAD, 4'd6, 32'h0, 32'h0, 8'h00, 1'b0, 3'd0);
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall got %b want 0", bus.stall); end
    tick();
    n_cmp++; if (bus.regWriteEn !== 1'b0 || bus.memErr !== 1'b0 || bus.stall !== 1'b0) begin n_fail++; $display("FAIL rstmid got %b/%b/%b want 0/0/0", bus.regWriteEn, bus.memErr, bus.stall); end
    rst = 1'b1;
    drive(`STORE, 4'd6, 32'h0, 32'h0, 8'h00, 1'b0, 3'd0);
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_run got %b want 0", bus.stall); end
    tick();
    n_cmp++; if (bus.regWriteEn !== 1'b0) begin n_fail++; $display("FAIL rstmid_nowr got %b want 0", bus.regWriteEn); end
  endtask
  initial begin
    bus.memReady = 1'b0; bus.dataIn = 32'd0;
    drive(`STORE, 4'd0, 32'd0, 32'd0, 8'd0, 1'b0, 3'd0);
    test_reset();
    test_alu();
    test_cmp_cond();
    test_load();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
